// File: rtl/mxint_block_accumulator.sv
// mxint_block_accumulator
//   Sums IN_DEPTH consecutive MxInt blocks (one shared exponent plus BLOCK_SIZE
//   signed mantissas) lane-wise into a single, wider, un-normalized MxInt block.
//   Each incoming block is aligned to the running maximum exponent before it is
//   added. The result goes on to mxint_cast for normalization and narrowing.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   mdata_in        BLOCK_SIZE signed input mantissas (IN_MAN_WIDTH bits each)
//   edata_in        shared input exponent (unsigned, biased)
//   data_in_valid   input handshake valid
//   data_in_ready   input handshake ready
//   mdata_out       BLOCK_SIZE signed accumulated mantissas (OUT_MAN_WIDTH bits)
//   edata_out       exponent of the accumulated block (same bias as the input)
//   data_out_valid  output handshake valid (registered)
//   data_out_ready  output handshake ready
module mxint_block_accumulator #(
  parameter int IN_MAN_WIDTH  = 8,
  parameter int IN_EXP_WIDTH  = 4,
  parameter int BLOCK_SIZE    = 4,
  parameter int IN_DEPTH      = 4,
  parameter int OUT_MAN_WIDTH = IN_MAN_WIDTH + $clog2(IN_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic signed [IN_MAN_WIDTH-1:0]  mdata_in [BLOCK_SIZE],
  input  logic        [IN_EXP_WIDTH-1:0]  edata_in,
  input  logic                            data_in_valid,
  output logic                            data_in_ready,
  output logic signed [OUT_MAN_WIDTH-1:0] mdata_out [BLOCK_SIZE],
  output logic        [IN_EXP_WIDTH-1:0]  edata_out,
  output logic                            data_out_valid,
  input  logic                            data_out_ready
);

  localparam int CNT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_DEPTH - 1);

  logic        [CNT_W-1:0]         cnt;
  logic signed [OUT_MAN_WIDTH-1:0] acc [BLOCK_SIZE];
  logic        [IN_EXP_WIDTH-1:0]  e_acc;

  logic                            in_fire;
  logic                            first;
  logic                            last;
  logic                            in_gt;
  logic        [IN_EXP_WIDTH-1:0]  d;
  logic        [IN_EXP_WIDTH-1:0]  acc_shamt;
  logic        [IN_EXP_WIDTH-1:0]  in_shamt;
  logic        [IN_EXP_WIDTH-1:0]  e_next;
  logic signed [OUT_MAN_WIDTH-1:0] ext  [BLOCK_SIZE];
  logic signed [OUT_MAN_WIDTH-1:0] sum  [BLOCK_SIZE];

  // Arithmetic right shift that saturates to pure sign fill once the shift
  // reaches the operand width, so no out-of-range shift amount is ever used.
  function automatic logic signed [OUT_MAN_WIDTH-1:0] ashr(
    input logic signed [OUT_MAN_WIDTH-1:0] x,
    input logic        [IN_EXP_WIDTH-1:0]  sh
  );
    if (int'(sh) >= OUT_MAN_WIDTH)
      return {OUT_MAN_WIDTH{x[OUT_MAN_WIDTH-1]}};
    else
      return x >>> sh;
  endfunction

  // Only the last block of a group can be blocked by a pending result.
  assign data_in_ready = (cnt != LAST) || !data_out_valid || data_out_ready;
  assign in_fire       = data_in_valid && data_in_ready;
  assign first         = (cnt == '0);
  assign last          = (cnt == LAST);

  // Whichever operand carries the smaller exponent is shifted down to the
  // larger one; the other operand is passed with a zero shift.
  always_comb begin
    in_gt     = edata_in > e_acc;
    d         = in_gt ? (edata_in - e_acc) : (e_acc - edata_in);
    acc_shamt = in_gt ? d : '0;
    in_shamt  = in_gt ? '0 : d;
    e_next    = (first || in_gt) ? edata_in : e_acc;
    for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
      ext[i] = OUT_MAN_WIDTH'(mdata_in[i]);
      if (first)
        sum[i] = ext[i];
      else
        sum[i] = ashr(acc[i], acc_shamt) + ashr(ext[i], in_shamt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      e_acc          <= '0;
      edata_out      <= '0;
      data_out_valid <= 1'b0;
      for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
        acc[i]       <= '0;
        mdata_out[i] <= '0;
      end
    end else begin
      if (in_fire) begin
        if (last) begin
          // Final sum bypasses the accumulator straight into the output
          // register; the accumulator is cleared for the next group.
          cnt       <= '0;
          e_acc     <= '0;
          edata_out <= e_next;
          for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
            acc[i]       <= '0;
            mdata_out[i] <= sum[i];
          end
        end else begin
          cnt   <= cnt + 1'b1;
          e_acc <= e_next;
          for (int unsigned i = 0; i < BLOCK_SIZE; i++)
            acc[i] <= sum[i];
        end
      end

      if (in_fire && last)
        data_out_valid <= 1'b1;
      else if (data_out_ready)
        data_out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mxint_block_accumulator.md
Name: mxint_block_accumulator

Overview:
- Accumulates IN_DEPTH consecutive MxInt blocks (shared exponent, BLOCK_SIZE signed mantissas) into one MxInt block, lane-wise.
- Aligns every incoming block to the running maximum exponent before adding.
- The result is not normalized, and its mantissa is wider than the input mantissa.
- Sits directly upstream of mxint_cast, which normalizes the result and narrows it to the next layer's format.

Parameters:
- IN_MAN_WIDTH, 8, input mantissa width (signed two's complement).
- IN_EXP_WIDTH, 4, exponent width (unsigned, biased); input and output use the same bias.
- BLOCK_SIZE, 4, mantissas per block.
- IN_DEPTH, 4, blocks summed per output block; must be >= 1.
- OUT_MAN_WIDTH, IN_MAN_WIDTH+$clog2(IN_DEPTH), accumulator/output mantissa width; must be >= that default.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- mdata_in  in  IN_MAN_WIDTH x [BLOCK_SIZE]  signed input mantissas (unpacked array).
- edata_in  in  IN_EXP_WIDTH  input shared exponent.
- data_in_valid  in  1  input valid.
- data_in_ready  out  1  input ready.
- mdata_out  out  OUT_MAN_WIDTH x [BLOCK_SIZE]  signed accumulated mantissas (unpacked array).
- edata_out  out  IN_EXP_WIDTH  exponent of the accumulated block.
- data_out_valid  out  1  output valid.
- data_out_ready  in  1  output ready.

Behaviour:
Clock, reset and handshake:
- Single clock clk; rst is asynchronous and active-high.
- Transfer occurs when valid && ready; valid/ready handshake on both sides.
- Reset (asynchronous, any time, including mid-group): block counter=0, accumulator lanes=0, accumulator exponent=0, mdata_out=0, edata_out=0, data_out_valid=0. A partial group is discarded.

Counter and accumulation:
- Block counter cnt runs 0..IN_DEPTH-1, advances on each input transfer, and wraps to 0 after the last block.
- cnt==0 transfer (first block): acc[i] = sign-extended mdata_in[i]; e_acc = edata_in.
- cnt>0 transfer, with d = |edata_in - e_acc| compared unsigned:
  - edata_in > e_acc: acc[i] = (acc[i] >>> d) + sext(mdata_in[i]); e_acc = edata_in.
  - edata_in <= e_acc: acc[i] = acc[i] + (sext(mdata_in[i]) >>> d).
- Arithmetic right shift truncates toward -inf.
- If d >= OUT_MAN_WIDTH, the shifted operand becomes -1 when negative and 0 otherwise. No shift by an out-of-range amount.
- No overflow can occur. Each aligned term has magnitude <= 2^(IN_MAN_WIDTH-1), so the sum of IN_DEPTH terms fits in OUT_MAN_WIDTH. No saturation logic.

Output register:
- Transfer with cnt==IN_DEPTH-1 (last block): the final sum (same formulas) and e_acc are written directly to mdata_out/edata_out. data_out_valid goes 1 on the next edge, giving 1-cycle latency after the last block transfer.
- The accumulator state is reset for the next group; the next block is treated as cnt==0.
- IN_DEPTH==1: every transfer is both first and last, so the block is passed through sign-extended with 1-cycle latency.
- data_out_valid stays 1 and outputs stay stable until data_out_ready; it then clears unless a new last block transfers in the same cycle, in which case it stays 1 with new data.

Ready rule and throughput:
- data_in_ready = (cnt != IN_DEPTH-1) || !data_out_valid || data_out_ready.
- Blocks 0..IN_DEPTH-2 of the next group are accepted while a result is still pending; only the last block stalls.
- Sustained throughput: one block per cycle. No combinational path from data_in_valid to data_in_ready.

Simultaneous events:
- Output drain plus last-block accept in the same cycle: the output register is overwritten with the new result and valid stays 1.
- data_in_valid with ready low: no state change.

Test Plan:
All scenarios use defaults: IN_MAN_WIDTH=8, IN_EXP_WIDTH=4, BLOCK_SIZE=4, IN_DEPTH=4, OUT_MAN_WIDTH=10.
- Equal exponents: 4 blocks of {1,2,-3,127} at exp 7, data_out_ready=1 -> mdata_out={4,8,-12,508}, edata_out=7, valid exactly 1 cycle after the 4th transfer, high for 1 cycle.
- Rising exponent: {64,-64,32,0}@5, {0,0,0,0}@7, {3,3,3,3}@5, {0,0,0,0}@5 -> {16,-16,8,0} after block 2, then +{0,0,0,0} (3>>>2=0) -> out {16,-16,8,0}, exp 7.
- Large exponent gap: {-5,5,0,0}@0, {1,1,1,1}@15, two zero blocks @0 -> accumulator aligns to {-1,0,0,0} -> out {0,1,1,1}, exp 15.
- Extremes: 4 blocks of {-128,-128,127,0}@3 -> out {-512,-512,508,0}, exp 3, no wrap.
- Backpressure: hold data_out_ready=0 after the first result.
  - Next group blocks 1-3 are accepted.
  - data_in_ready=0 at block 4 while outputs stay stable.
  - Raise ready -> same-cycle drain plus accept; the new result appears on the next cycle.
- Mid-group reset: after 2 blocks, pulse rst asynchronously (between edges) -> data_out_valid=0, mdata_out=0, edata_out=0 immediately. The next 4 blocks of {1,1,1,1}@2 give {4,4,4,4}@2.
